// File: rtl/gpr_wb_pkg.sv
// Shared types for the GPR write-back queue.
// Entry index is stored at a fixed maximum width and zero-extended from IDX_W.
package gpr_wb_pkg;

  localparam int DATA_W    = 32;
  localparam int IDX_MAX_W = 8;
  localparam int MAX_GPR   = 1 << IDX_MAX_W;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  // Out-of-range indices yield an all-zero vector so the write is dropped.
  function automatic logic [MAX_GPR-1:0] onehot(
    input logic [IDX_MAX_W-1:0] idx,
    input int unsigned          num_gpr
  );
    logic [MAX_GPR-1:0] oh;
    oh = '0;
    if (32'(idx) < num_gpr) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Circular storage for the write-back queue: pointers, count, full flag
// and a per-entry valid vector used by the hazard compare.
module gpr_wb_fifo
  import gpr_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  wb_entry_t       din_i,
  output wb_entry_t       head_o,
  output wb_entry_t       mem_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [PW-1:0]   rd_ptr_o,
  output logic [CW-1:0]   count_o,
  output logic            full_o,
  output logic            pop_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             push_ok, pop_ok, full, empty;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // Push and pop are judged on the pre-edge state: no pass-through.
  assign push_ok = push_i & ~full;
  assign pop_ok  = pop_i & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push_ok) begin
      wr_ptr_d          = wr_ptr_q + 1'b1;
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d          = rd_ptr_q + 1'b1;
      valid_d[rd_ptr_q] = 1'b0;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign mem_o    = mem_q;
  assign valid_o  = valid_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = full;
  assign pop_o    = pop_ok;

endmodule

// File: rtl/gpr_wb_queue.sv
// Write-back queue feeding the GPR array, with RAW hazard flags.
// Define GPR_WB_BYPASS_EN to add byp_a_data/byp_b_data forwarding outputs.
module gpr_wb_queue
  import gpr_wb_pkg::*;
#(
  parameter  int NUM_GPR = 32,
  parameter  int IDX_W   = 5,
  parameter  int DEPTH   = 4,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_valid,
  output logic               wb_ready,
  input  logic [IDX_W-1:0]   wb_idx,
  input  logic [31:0]        wb_data,
  input  logic               drain_hold,
  output logic [NUM_GPR-1:0] gpr_wt_en,
  output logic [31:0]        gpr_data_in,
  input  logic [IDX_W-1:0]   rd_a_idx,
  input  logic [IDX_W-1:0]   rd_b_idx,
  output logic               hazard_a,
  output logic               hazard_b,
`ifdef GPR_WB_BYPASS_EN
  output logic [31:0]        byp_a_data,
  output logic [31:0]        byp_b_data,
`endif
  output logic [CW-1:0]      count
);

  wb_entry_t        din, head;
  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    rd_ptr;
  logic             full, pop;

  logic [NUM_GPR-1:0] wt_en_q, wt_en_d;
  logic [31:0]        data_q, data_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;

  logic [IDX_MAX_W-1:0] a_ext, b_ext;

  assign din.idx  = IDX_MAX_W'(wb_idx);
  assign din.data = wb_data;

  gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (wb_valid),
    .pop_i    (~drain_hold),
    .din_i    (din),
    .head_o   (head),
    .mem_o    (mem),
    .valid_o  (valid),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .pop_o    (pop)
  );

  assign wb_ready = ~full;

  always_comb begin
    wt_en_d   = '0;
    data_d    = data_q;
    out_idx_d = out_idx_q;
    if (pop) begin
      wt_en_d   = NUM_GPR'(onehot(head.idx, NUM_GPR));
      data_d    = head.data;
      out_idx_d = head.idx[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wt_en_q   <= '0;
      data_q    <= '0;
      out_idx_q <= '0;
    end else begin
      wt_en_q   <= wt_en_d;
      data_q    <= data_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign gpr_wt_en   = wt_en_q;
  assign gpr_data_in = data_q;

  assign a_ext = IDX_MAX_W'(rd_a_idx);
  assign b_ext = IDX_MAX_W'(rd_b_idx);

  // Walk oldest to newest so the last match is the youngest write.
  always_comb begin
    logic [PW-1:0] p;
    logic          live;
    hazard_a = 1'b0;
    hazard_b = 1'b0;
`ifdef GPR_WB_BYPASS_EN
    byp_a_data = '0;
    byp_b_data = '0;
`endif
    if (|wt_en_q && out_idx_q == rd_a_idx) begin
      hazard_a = 1'b1;
`ifdef GPR_WB_BYPASS_EN
      byp_a_data = data_q;
`endif
    end
    if (|wt_en_q && out_idx_q == rd_b_idx) begin
      hazard_b = 1'b1;
`ifdef GPR_WB_BYPASS_EN
      byp_b_data = data_q;
`endif
    end
    for (int k = 0; k < DEPTH; k++) begin
      p    = rd_ptr + PW'(k);
      live = valid[p] && (32'(mem[p].idx) < NUM_GPR);
      if (live && mem[p].idx == a_ext) begin
        hazard_a = 1'b1;
`ifdef GPR_WB_BYPASS_EN
        byp_a_data = mem[p].data;
`endif
      end
      if (live && mem[p].idx == b_ext) begin
        hazard_b = 1'b1;
`ifdef GPR_WB_BYPASS_EN
        byp_b_data = mem[p].data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Directed bench for gpr_wb_queue (IDX_W=6 so out-of-range indices exist).
module tb_gpr_wb_queue;

  localparam int NUM_GPR = 32;
  localparam int IDX_W   = 6;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               wb_valid;
  logic               wb_ready;
  logic [IDX_W-1:0]   wb_idx;
  logic [31:0]        wb_data;
  logic               drain_hold;
  logic [NUM_GPR-1:0] gpr_wt_en;
  logic [31:0]        gpr_data_in;
  logic [IDX_W-1:0]   rd_a_idx;
  logic [IDX_W-1:0]   rd_b_idx;
  logic               hazard_a;
  logic               hazard_b;
  logic [CW-1:0]      count;
`ifdef GPR_WB_BYPASS_EN
  logic [31:0]        byp_a_data;
  logic [31:0]        byp_b_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpr_wb_queue #(
    .NUM_GPR(NUM_GPR),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_idx     (wb_idx),
    .wb_data    (wb_data),
    .drain_hold (drain_hold),
    .gpr_wt_en  (gpr_wt_en),
    .gpr_data_in(gpr_data_in),
    .rd_a_idx   (rd_a_idx),
    .rd_b_idx   (rd_b_idx),
    .hazard_a   (hazard_a),
    .hazard_b   (hazard_b),
`ifdef GPR_WB_BYPASS_EN
    .byp_a_data (byp_a_data),
    .byp_b_data (byp_b_data),
`endif
    .count      (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_idx   = idx;
    wb_data  = d;
    step();
    wb_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic [IDX_W-1:0] ix [4];
    rst = 1'b1;
    wb_valid = 1'b0;
    wb_idx = '0;
    wb_data = '0;
    drain_hold = 1'b0;
    rd_a_idx = '0;
    rd_b_idx = '0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_wten", gpr_wt_en, 0);
    chk("rst_data", gpr_data_in, 0);
    chk("rst_ready", wb_ready, 1);
    chk("rst_haz", {hazard_a, hazard_b}, 0);
    #10 rst = 1'b0;

    // 1: single write latency
    push(6'd3, 32'hDEADBEEF);
    chk("t1_count1", count, 1);
    chk("t1_wten_e1", gpr_wt_en, 0);
    step();
    chk("t1_wten_e2", gpr_wt_en, 64'h8);
    chk("t1_data_e2", gpr_data_in, 64'hDEADBEEF);
    chk("t1_count0", count, 0);
    step();
    chk("t1_wten_e3", gpr_wt_en, 0);
    chk("t1_data_hold", gpr_data_in, 64'hDEADBEEF);

    // 2: fill while held, reject 5th, drain in order
    drain_hold = 1'b1;
    ix = '{6'd1, 6'd2, 6'd4, 6'd8};
    for (int i = 0; i < 4; i++) push(ix[i], 32'h11 * (i + 1));
    chk("t2_count4", count, 4);
    chk("t2_ready0", wb_ready, 0);
    rd_a_idx = 6'd4;
    rd_b_idx = 6'd5;
    #1;
    chk("t2_haz_a", hazard_a, 1);
    chk("t2_haz_b", hazard_b, 0);
    push(6'd9, 32'h99);
    chk("t2_reject", count, 4);
    drain_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_wten", gpr_wt_en, 64'(1) << ix[i]);
      chk("t2_data", gpr_data_in, 32'h11 * (i + 1));
      chk("t2_count", count, 3 - i);
    end
    step();
    chk("t2_idle", gpr_wt_en, 0);

    // 3: same-index hazard
    rd_a_idx = 6'd7;
    rd_b_idx = 6'd6;
    push(6'd7, 32'h1);
    chk("t3_haz1", hazard_a, 1);
    chk("t3_count1", count, 1);
    push(6'd7, 32'h2);
    chk("t3_count_pp", count, 1);
    chk("t3_wten_a", gpr_wt_en, 64'h80);
    chk("t3_data_a", gpr_data_in, 1);
    chk("t3_haz2", hazard_a, 1);
    chk("t3_hazb", hazard_b, 0);
`ifdef GPR_WB_BYPASS_EN
    chk("t3_byp_q", byp_a_data, 2);
`endif
    step();
    chk("t3_wten_b", gpr_wt_en, 64'h80);
    chk("t3_data_b", gpr_data_in, 2);
    chk("t3_haz3", hazard_a, 1);
`ifdef GPR_WB_BYPASS_EN
    chk("t3_byp_f", byp_a_data, 2);
`endif
    step();
    chk("t3_wten_0", gpr_wt_en, 0);
    chk("t3_haz0", hazard_a, 0);
`ifdef GPR_WB_BYPASS_EN
    chk("t3_byp_0", byp_a_data, 0);
`endif

    // 4: out-of-range index
    rd_a_idx = 6'd40;
    rd_b_idx = 6'd8;
    push(6'd40, 32'h40404040);
    chk("t4_count1", count, 1);
    chk("t4_haz", {hazard_a, hazard_b}, 0);
    step();
    chk("t4_count0", count, 0);
    chk("t4_wten", gpr_wt_en, 0);
    chk("t4_data", gpr_data_in, 64'h40404040);
    chk("t4_haz2", {hazard_a, hazard_b}, 0);

    // 5: full with simultaneous push+pop
    rd_a_idx = '0;
    rd_b_idx = '0;
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(IDX_W'(10 + i), 32'hA0 + i);
    chk("t5_count4", count, 4);
    drain_hold = 1'b0;
    wb_valid = 1'b1;
    wb_idx = 6'd14;
    wb_data = 32'hE;
    step();
    wb_valid = 1'b0;
    #1;
    chk("t5_count3", count, 3);
    chk("t5_wten", gpr_wt_en, 64'(1) << 10);
    chk("t5_ready", wb_ready, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t5_order", gpr_wt_en, 64'(1) << (10 + i));
      chk("t5_odata", gpr_data_in, 32'hA0 + i);
    end
    step();
    chk("t5_no14", gpr_wt_en, 0);
    chk("t5_empty", count, 0);

    // 6: reset mid-drain
    drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(IDX_W'(20 + i), 32'h20 + i);
    drain_hold = 1'b0;
    step();
    chk("t6_wten", gpr_wt_en, 64'(1) << 20);
    chk("t6_count2", count, 2);
    rd_a_idx = 6'd21;
    #1;
    chk("t6_haz_pre", hazard_a, 1);
    rst = 1'b1;
    #1;
    chk("t6_rcount", count, 0);
    chk("t6_rwten", gpr_wt_en, 0);
    chk("t6_rdata", gpr_data_in, 0);
    chk("t6_rhaz", hazard_a, 0);
    chk("t6_rready", wb_ready, 1);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_nowr", gpr_wt_en, 0);
      chk("t6_cnt", count, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
